// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock, start/busy/done handshake.
// Build option SERIAL_ADDSUB_SUB_EN enables subtract mode; otherwise every operation is an add.
module serial_addsub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         c,
  output logic         ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ra_q, ra_d;
  logic [W-1:0]   rb_q, rb_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   s_q, s_d;
  logic           c_q, c_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic           sub_eff;
  logic           sum_bit;
  logic           cout_bit;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  always_comb begin
    sum_bit  = ra_q[0] ^ rb_q[0] ^ carry_q;
    cout_bit = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);

    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          ra_d    = a;
          rb_d    = sub_eff ? ~b : b;
          carry_d = sub_eff;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = {sum_bit, acc_q[W-1:1]};
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        carry_d = cout_bit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // carry_q is the carry into the MSB on this last bit.
          s_d     = {sum_bit, acc_q[W-1:1]};
          c_d     = cout_bit;
          ovf_d   = carry_q ^ cout_bit;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub (W=8) against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c, ovf;
  logic [W-1:0] s;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [W-1:0] es;
  logic         ec, eo;

  serial_addsub #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       output logic [W-1:0] ms, output logic mc, output logic mo);
    int ua, ub, sa, sb, ur, sr;
    logic eff;
`ifdef SERIAL_ADDSUB_SUB_EN
    eff = msub;
`else
    eff = 1'b0;
`endif
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (eff) begin
      ur = ua - ub;
      sr = sa - sb;
      mc = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      mc = (ur >= (1 << W));
    end
    ms = W'(ur);
    mo = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  // Called at a negedge: presents a request and records the expected results.
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lsub);
    start = 1'b1;
    a = la;
    b = lb;
    sub = lsub;
    model(la, lb, lsub, es, ec, eo);
  endtask

  // Walks edges E0..E0+W, checking busy/done every cycle and the results in the done cycle.
  task automatic finish_op(input string tag, input bit hold, input bit intrude);
    for (int k = 0; k <= W; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0 && !hold) begin
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sub = 1'($urandom);
      end
      if (intrude && k == 2) begin
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
        sub = ~sub;
      end
      if (intrude && k == 3) start = 1'b0;
      chk({tag, ".busy"}, busy, (k < W));
      chk({tag, ".done"}, done, (k == W));
    end
    chk({tag, ".s"}, s, es);
    chk({tag, ".c"}, c, ec);
    chk({tag, ".ovf"}, ovf, eo);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] la, input logic [W-1:0] lb,
                          input logic lsub, input logic [W-1:0] xs, input logic xc, input logic xo);
    launch(la, lb, lsub);
    es = xs;
    ec = xc;
    eo = xo;
    finish_op(tag, 1'b0, 1'b0);
  endtask

  initial begin
    bit seen_done;

    #2;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.s", s, 0);
    chk("rst.c", c, 0);
    chk("rst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    directed("add100_27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    directed("add200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0);
    directed("add100_50", 8'd100, 8'd50, 1'b0, 8'h96, 1'b0, 1'b1);
`ifdef SERIAL_ADDSUB_SUB_EN
    directed("sub5_7", 8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed("sub80_1", 8'h80, 8'd1, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
    directed("nosub5_7", 8'd5, 8'd7, 1'b1, 8'd12, 1'b0, 1'b0);
`endif

    // A start pulse while busy must be ignored; then back-to-back from the done cycle.
    directed("idle_gap", 8'd1, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0);
    launch(8'd10, 8'd20, 1'b0);
    es = 8'd30; ec = 1'b0; eo = 1'b0;
    finish_op("intrude", 1'b0, 1'b1);
    launch(8'd1, 8'd1, 1'b0);
    es = 8'd2; ec = 1'b0; eo = 1'b0;
    finish_op("b2b", 1'b0, 1'b0);
    @(negedge clk);
    chk("after_b2b.done", done, 0);
    chk("after_b2b.busy", busy, 0);

    // Asynchronous reset mid-operation.
    launch(8'hFF, 8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.s", s, 0);
    chk("arst.c", c, 0);
    chk("arst.ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("arst.no_done", seen_done, 0);
    directed("add3_4", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0);

    // Continuous start: a new operation every W+1 cycles.
    launch(8'd1, 8'd1, 1'b0);
    for (int n = 0; n < 3; n++) finish_op("hold", 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      launch(8'($urandom), 8'($urandom), 1'($urandom));
      finish_op("rand", 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor: one full-adder slice processes operands LSB-first, one bit per clock, under a start/busy/done handshake. It is the next generation of the team's fixed 4-bit serial adder, generalised to width `W`, with:
- explicit start instead of load-on-reset,
- add/subtract mode,
- carry and signed-overflow flags.

It sits in area-constrained datapaths where an operation may take W cycles.

## Interface
Parameters:
- `W`, default 8: operand/result width; legal range W ≥ 2.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request. Sampled only in IDLE.
- `sub`  in  1: mode, sampled with `start`. 0 = add (a+b), 1 = subtract (a−b).
- `a`  in  W: operand A, sampled with `start`.
- `b`  in  W: operand B, sampled with `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when results update.
- `s`  out  W: result, modulo 2^W.
- `c`  out  1: carry out of the MSB. In subtract mode, 1 = no borrow (a ≥ b unsigned).
- `ovf`  out  1: two's-complement signed overflow.

## Operation
State machine:
- IDLE → RUN when `start`=1 at a clock edge.
  - Capture `a` into the shift register `ra`.
  - Capture `b` into `rb`; if subtracting, capture `~b` instead.
  - Initialise carry to the subtract flag; clear bit counter and result shift register.
- RUN, each cycle:
  - Full adder on `ra[0]`, `rb[0]`, carry.
  - Sum bit shifts into the MSB of the result register; result register shifts right.
  - `ra` and `rb` shift right; carry register takes the carry-out; counter increments.
- RUN → IDLE at the edge processing bit W−1. At that edge:
  - `s` ← final result; `c` ← carry-out of the MSB.
  - `ovf` ← (carry into MSB) XOR (carry out of MSB).
  - `done` ← 1.
- Counter width is $clog2(W); wrap-around is never reached.
- `start` while busy is ignored; operands and `sub` are not resampled.
- `a`, `b` and `sub` may change freely after the capture edge.
- `s`, `c` and `ovf` hold their values until the next completion.

Reset (async, any time, including mid-RUN):
- State → IDLE; `busy`=0, `done`=0, `s`=0, `c`=0, `ovf`=0.
- Internal registers and counter cleared; the in-flight operation is discarded and produces no `done`.

## Timing
- Capture edge = E0.
- `busy`=1 from after E0 through the cycle ending at edge E0+W (W cycles).
- Results and `done` are valid in the cycle after E0+W. Latency is W+1 edges from the start edge, counting E0.
- `done` lasts exactly one cycle.
- In the `done` cycle the block is IDLE: `start`=1 there is accepted, giving back-to-back operations with a throughput of one per W+1 cycles.
- `busy` and `done` are never high together.

## Configuration
Macro `SERIAL_ADDSUB_SUB_EN`:
- Defined: `sub` is honoured as described above.
- Undefined:
  - Subtract logic is compiled out; `sub` is ignored and every operation is an add with carry-in 0.
  - The port remains, so the interface is identical.
  - `c` and `ovf` follow the add rules.

## Test plan
All scenarios use W=8.
1. Add 100+27 → `s`=127, `c`=0, `ovf`=0.
   - `busy` is high 8 cycles; `done` pulses once, 9 edges after the start edge.
2. Add 200+100 → `s`=44, `c`=1, `ovf`=0.
   Then add 100+50 → `s`=150 (0x96), `c`=0, `ovf`=1.
3. With `SERIAL_ADDSUB_SUB_EN`:
   - Sub 5−7 → `s`=0xFE, `c`=0, `ovf`=0.
   - Sub 0x80−1 → `s`=0x7F, `c`=1, `ovf`=1.
   - Without the macro, 5 with `sub`=1 and `b`=7 → `s`=12.
4. Start 10+20; pulse `start` with different operands on busy cycle 3.
   → Result `s`=30; only one `done`.
   Then assert `start` with 1+1 in the `done` cycle → second `done` after W+1 edges with `s`=2.
5. Assert `rst` asynchronously mid-RUN, at bit 3 of 0xFF+0x01.
   → `busy`, `done`, `s`, `c`, `ovf` all 0 immediately; no `done` follows.
   After release, 3+4 → `s`=7.
6. Hold `start`=1 continuously with a=1, b=1 → `done` every 9 cycles, `s`=2 each time.
